// File: rtl/spi_master_engine_pkg.sv
// rtl/spi_master_engine_pkg.sv - state encodings and sizing helpers for the SPI master engine
package spi_master_engine_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_PUSH  = 3'd4;
    localparam logic [2:0] ST_HOLD  = 3'd5;
    localparam logic [2:0] ST_DESEL = 3'd6;

    // Edge counter must hold the value 2*data_width (the final edge number).
    function automatic int edge_cnt_w(input int data_width);
        return $clog2(2 * data_width) + 1;
    endfunction

endpackage

// File: rtl/spi_master_engine_if.sv
// rtl/spi_master_engine_if.sv - FIFO-side and SPI-pin bundle for the SPI master engine
interface spi_master_engine_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tx_empty;
    logic [DATA_WIDTH-1:0] tx_dout;
    logic                  tx_rd_en;
    logic                  rx_full;
    logic [DATA_WIDTH-1:0] rx_din;
    logic                  rx_wr_en;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;
    logic                  cs_n;

    modport master (
        input  tx_empty, tx_dout, rx_full, miso,
        output tx_rd_en, rx_din, rx_wr_en, sclk, mosi, cs_n
    );

    modport slave (
        output tx_empty, tx_dout, rx_full, miso,
        input  tx_rd_en, rx_din, rx_wr_en, sclk, mosi, cs_n
    );
endinterface

// File: rtl/spi_master_engine_clk_tick.sv
// rtl/spi_master_engine_clk_tick.sv - half-period counter producing one tick every div+1 cycles
module spi_clk_tick #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt;

    // Count 0..div while running; held at 0 when stopped so each run starts fresh.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt <= '0;
        end else if (cnt == div) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_WIDTH'(1);
        end
    end

    assign tick = run && (cnt == div);

endmodule

// File: rtl/spi_master_engine.sv
// rtl/spi_master_engine.sv - byte-serial SPI master between TX and RX FIFOs
module spi_master_engine
    import spi_master_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic [DIV_WIDTH-1:0] clk_div,
    output logic                 busy,
    spi_master_engine_if.master  bus
);

    localparam int                EW        = edge_cnt_w(DATA_WIDTH);
    localparam logic [EW-1:0]     LAST_EDGE = EW'(2 * DATA_WIDTH);

    logic [2:0]            state;
    logic                  cpol_q;
    logic                  cpha_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic [DATA_WIDTH-1:0] rx_din_q;
    logic [EW-1:0]         edge_cnt;
    logic [EW-1:0]         next_edge;
    logic                  sclk_q;
    logic                  mosi_q;
    logic                  cs_n_q;
    logic                  tick_run;
    logic                  tick;
    logic                  can_start;

    // The counter paces SCLK edges and also times the cs_n hold and deselect gaps.
    assign tick_run  = (state == ST_SHIFT) || (state == ST_HOLD) || (state == ST_DESEL);
    assign next_edge = edge_cnt + EW'(1);
    assign can_start = !bus.tx_empty && !bus.rx_full;

    spi_clk_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .run   (tick_run),
        .div   (div_q),
        .tick  (tick)
    );

    // Frame sequencer: fetch, shift 2*DATA_WIDTH edges, push, then either chain or deselect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            div_q    <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_din_q <= '0;
            edge_cnt <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_n_q   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    sclk_q <= cpol;
                    if (can_start) begin
                        cpol_q <= cpol;
                        cpha_q <= cpha;
                        div_q  <= clk_div;
                        state  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    tx_sh    <= bus.tx_dout;
                    rx_sh    <= '0;
                    edge_cnt <= '0;
                    cs_n_q   <= 1'b0;
                    if (!cpha_q) begin
                        mosi_q <= bus.tx_dout[DATA_WIDTH-1];
                    end
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (tick) begin
                        sclk_q   <= ~sclk_q;
                        edge_cnt <= next_edge;
                        if (next_edge[0]) begin
                            // Leading edge: sample for mode 0, launch next bit for mode 1.
                            if (!cpha_q) begin
                                rx_sh <= {rx_sh[DATA_WIDTH-2:0], bus.miso};
                            end else begin
                                mosi_q <= tx_sh[DATA_WIDTH-1];
                                tx_sh  <= tx_sh << 1;
                            end
                        end else begin
                            // Trailing edge: sample for mode 1, launch next bit for mode 0.
                            if (cpha_q) begin
                                rx_sh <= {rx_sh[DATA_WIDTH-2:0], bus.miso};
                            end else if (next_edge != LAST_EDGE) begin
                                mosi_q <= tx_sh[DATA_WIDTH-2];
                                tx_sh  <= tx_sh << 1;
                            end
                        end
                        if (next_edge == LAST_EDGE) begin
                            rx_din_q <= cpha_q ? {rx_sh[DATA_WIDTH-2:0], bus.miso} : rx_sh;
                            state    <= ST_PUSH;
                        end
                    end
                end
                ST_PUSH: begin
                    state <= can_start ? ST_FETCH : ST_HOLD;
                end
                ST_HOLD: begin
                    if (tick) begin
                        cs_n_q <= 1'b1;
                        state  <= ST_DESEL;
                    end
                end
                ST_DESEL: begin
                    if (tick) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_rd_en = (state == ST_FETCH);
    assign bus.rx_wr_en = (state == ST_PUSH);
    assign bus.rx_din   = rx_din_q;
    assign bus.sclk     = sclk_q;
    assign bus.mosi     = mosi_q;
    assign bus.cs_n     = cs_n_q;
    assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_master_engine.sv
// tb/tb_spi_master_engine.sv - directed self-checking bench for spi_master_engine
module tb_spi_master_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpol;
    logic       cpha;
    logic [7:0] clk_div;
    logic       busy;
    logic       loop_en;
    logic       miso_fix;
    logic       rx_full_r;
    logic [7:0] tx_dout_r = 8'h00;
    logic [7:0] tx_mem [0:63];
    int         tx_wr = 0;
    int         tx_rd = 0;

    int         errors = 0;
    int         checks = 0;

    int         cyc = 0;
    int         n_edge = 0;
    int         n_rd = 0;
    int         n_bad_rd = 0;
    int         n_rx = 0;
    int         n_cs_fall = 0;
    int         n_cs_rise = 0;
    logic       prev_sclk = 1'b0;
    logic       prev_cs = 1'b1;
    int         edge_cyc [0:1023];
    logic [7:0] rx_log [0:63];
    logic [31:0] mosi_log = 32'h0;

    always #5 clk = ~clk;

    spi_master_engine_if #(.DATA_WIDTH(8)) bus ();

    assign bus.tx_empty = (tx_wr == tx_rd);
    assign bus.tx_dout  = tx_dout_r;
    assign bus.rx_full  = rx_full_r;
    assign bus.miso     = loop_en ? bus.mosi : miso_fix;

    spi_master_engine #(
        .DATA_WIDTH (8),
        .DIV_WIDTH  (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cpol    (cpol),
        .cpha    (cpha),
        .clk_div (clk_div),
        .busy    (busy),
        .bus     (bus)
    );

    // TX FIFO model with registered read data, plus event logging of the SPI side.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        prev_sclk <= bus.sclk;
        prev_cs   <= bus.cs_n;
        if (bus.sclk !== prev_sclk) begin
            edge_cyc[n_edge % 1024] <= cyc;
            n_edge <= n_edge + 1;
            if ((cpha == 1'b0 && bus.sclk !== cpol) || (cpha == 1'b1 && bus.sclk === cpol))
                mosi_log <= {mosi_log[30:0], bus.mosi};
        end
        if (bus.tx_rd_en === 1'b1) begin
            n_rd <= n_rd + 1;
            if (tx_wr == tx_rd) n_bad_rd <= n_bad_rd + 1;
            tx_dout_r <= tx_mem[tx_rd % 64];
            tx_rd <= tx_rd + 1;
        end
        if (bus.rx_wr_en === 1'b1) begin
            rx_log[n_rx % 64] <= bus.rx_din;
            n_rx <= n_rx + 1;
        end
        if (bus.cs_n === 1'b0 && prev_cs === 1'b1) n_cs_fall <= n_cs_fall + 1;
        if (bus.cs_n === 1'b1 && prev_cs === 1'b0) n_cs_rise <= n_cs_rise + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    task automatic push(input logic [7:0] b);
        tx_mem[tx_wr % 64] = b;
        tx_wr = tx_wr + 1;
    endtask

    task automatic get_gaps(input int s, input int cnt, output int gmin, output int gmax);
        int g;
        gmin = 1 << 30;
        gmax = 0;
        for (int i = 1; i < cnt; i++) begin
            g = edge_cyc[(s + i) % 1024] - edge_cyc[(s + i - 1) % 1024];
            if (g < gmin) gmin = g;
            if (g > gmax) gmax = g;
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpol = 1'b1; cpha = 1'b0; clk_div = 8'd0;
        loop_en = 1'b1; miso_fix = 1'b0; rx_full_r = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.cs_n !== 1'b1)     begin errors++; $display("FAIL rst_cs_n: got %b want 1", bus.cs_n); end
        checks++; if (bus.sclk !== 1'b0)     begin errors++; $display("FAIL rst_sclk: got %b want 0", bus.sclk); end
        checks++; if (bus.mosi !== 1'b0)     begin errors++; $display("FAIL rst_mosi: got %b want 0", bus.mosi); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (bus.tx_rd_en !== 1'b0) begin errors++; $display("FAIL rst_tx_rd_en: got %b want 0", bus.tx_rd_en); end
        checks++; if (bus.rx_wr_en !== 1'b0) begin errors++; $display("FAIL rst_rx_wr_en: got %b want 0", bus.rx_wr_en); end
        checks++; if (bus.rx_din !== 8'h00)  begin errors++; $display("FAIL rst_rx_din: got %h want 00", bus.rx_din); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.sclk !== 1'b1)     begin errors++; $display("FAIL idle_sclk_cpol1: got %b want 1", bus.sclk); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
        checks++; if (n_rd !== 0)            begin errors++; $display("FAIL idle_no_rd: got %0d want 0", n_rd); end
        cpol = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode0_loopback();
        int s_edge, s_rd, s_rx, s_fall, s_rise, gmin, gmax;
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0; loop_en = 1'b1;
        repeat (2) @(negedge clk);
        s_edge = n_edge; s_rd = n_rd; s_rx = n_rx; s_fall = n_cs_fall; s_rise = n_cs_rise;
        push(8'hA5);
        wait_done(200, "m0");
        get_gaps(s_edge, 16, gmin, gmax);
        checks++; if (n_rd - s_rd !== 1)      begin errors++; $display("FAIL m0_rd_pulses: got %0d want 1", n_rd - s_rd); end
        checks++; if (n_edge - s_edge !== 16) begin errors++; $display("FAIL m0_edges: got %0d want 16", n_edge - s_edge); end
        checks++; if (gmin !== 1 || gmax !== 1) begin errors++; $display("FAIL m0_edge_gap: got min %0d max %0d want 1", gmin, gmax); end
        checks++; if (mosi_log[7:0] !== 8'hA5) begin errors++; $display("FAIL m0_mosi: got %h want a5", mosi_log[7:0]); end
        checks++; if (n_rx - s_rx !== 1)      begin errors++; $display("FAIL m0_rx_count: got %0d want 1", n_rx - s_rx); end
        checks++; if (rx_log[s_rx % 64] !== 8'hA5) begin errors++; $display("FAIL m0_rx_byte: got %h want a5", rx_log[s_rx % 64]); end
        checks++; if (n_cs_fall - s_fall !== 1 || n_cs_rise - s_rise !== 1)
            begin errors++; $display("FAIL m0_cs_n: got fall %0d rise %0d want 1/1", n_cs_fall - s_fall, n_cs_rise - s_rise); end
        checks++; if (bus.sclk !== 1'b0)      begin errors++; $display("FAIL m0_sclk_end: got %b want 0", bus.sclk); end
    endtask

    task automatic test_mode3_div3();
        int s_edge, s_rx, s_rd, gmin, gmax;
        cpol = 1'b1; cpha = 1'b1; clk_div = 8'd3; loop_en = 1'b0; miso_fix = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.sclk !== 1'b1)      begin errors++; $display("FAIL m3_idle_sclk: got %b want 1", bus.sclk); end
        s_edge = n_edge; s_rx = n_rx; s_rd = n_rd;
        push(8'h3C);
        wait_done(400, "m3");
        get_gaps(s_edge, 16, gmin, gmax);
        checks++; if (n_rd - s_rd !== 1)      begin errors++; $display("FAIL m3_rd_pulses: got %0d want 1", n_rd - s_rd); end
        checks++; if (n_edge - s_edge !== 16) begin errors++; $display("FAIL m3_edges: got %0d want 16", n_edge - s_edge); end
        checks++; if (gmin !== 4 || gmax !== 4) begin errors++; $display("FAIL m3_edge_gap: got min %0d max %0d want 4", gmin, gmax); end
        checks++; if (mosi_log[7:0] !== 8'h3C) begin errors++; $display("FAIL m3_mosi: got %h want 3c", mosi_log[7:0]); end
        checks++; if (n_rx - s_rx !== 1)      begin errors++; $display("FAIL m3_rx_count: got %0d want 1", n_rx - s_rx); end
        checks++; if (rx_log[s_rx % 64] !== 8'hFF) begin errors++; $display("FAIL m3_rx_byte: got %h want ff", rx_log[s_rx % 64]); end
        checks++; if (bus.sclk !== 1'b1)      begin errors++; $display("FAIL m3_sclk_end: got %b want 1", bus.sclk); end
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0; loop_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int s_edge, s_rd, s_rx, s_fall, s_rise;
        logic [7:0] exp_b [0:2];
        exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h03;
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd1; loop_en = 1'b1;
        repeat (2) @(negedge clk);
        s_edge = n_edge; s_rd = n_rd; s_rx = n_rx; s_fall = n_cs_fall; s_rise = n_cs_rise;
        for (int i = 0; i < 3; i++) push(exp_b[i]);
        wait_done(600, "b2b");
        checks++; if (n_rd - s_rd !== 3)      begin errors++; $display("FAIL b2b_rd_pulses: got %0d want 3", n_rd - s_rd); end
        checks++; if (n_rx - s_rx !== 3)      begin errors++; $display("FAIL b2b_rx_count: got %0d want 3", n_rx - s_rx); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rx_log[(s_rx + i) % 64] !== exp_b[i]) begin
                errors++; $display("FAIL b2b_rx_byte%0d: got %h want %h", i, rx_log[(s_rx + i) % 64], exp_b[i]);
            end
        end
        checks++; if (n_cs_fall - s_fall !== 1 || n_cs_rise - s_rise !== 1)
            begin errors++; $display("FAIL b2b_cs_n: got fall %0d rise %0d want 1/1", n_cs_fall - s_fall, n_cs_rise - s_rise); end
        checks++; if (n_edge - s_edge !== 48) begin errors++; $display("FAIL b2b_edges: got %0d want 48", n_edge - s_edge); end
    endtask

    task automatic test_rx_full();
        int s_rd, s_rx;
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0; loop_en = 1'b1;
        rx_full_r = 1'b1;
        @(negedge clk);
        s_rd = n_rd; s_rx = n_rx;
        push(8'h5A);
        repeat (10) @(negedge clk);
        checks++; if (n_rd - s_rd !== 0)      begin errors++; $display("FAIL full_no_rd: got %0d want 0", n_rd - s_rd); end
        checks++; if (bus.cs_n !== 1'b1)      begin errors++; $display("FAIL full_cs_n: got %b want 1", bus.cs_n); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL full_busy: got %b want 0", busy); end
        rx_full_r = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (n_rd - s_rd !== 1)      begin errors++; $display("FAIL full_release_rd: got %0d want 1", n_rd - s_rd); end
        wait_done(200, "full");
        checks++; if (rx_log[s_rx % 64] !== 8'h5A || n_rx - s_rx !== 1)
            begin errors++; $display("FAIL full_rx_byte: got %h (count %0d) want 5a (count 1)", rx_log[s_rx % 64], n_rx - s_rx); end
    endtask

    task automatic test_reset_mid_frame();
        int s_edge, s_rx, n;
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd2; loop_en = 1'b1;
        repeat (2) @(negedge clk);
        s_edge = n_edge; s_rx = n_rx;
        push(8'hC3);
        n = 0;
        while (n_edge - s_edge < 7 && n < 200) begin @(negedge clk); n++; end
        checks++; if (n >= 200) begin errors++; $display("FAIL abort_edge7_timeout: edges %0d want 7", n_edge - s_edge); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.cs_n !== 1'b1)      begin errors++; $display("FAIL abort_cs_n: got %b want 1", bus.cs_n); end
        checks++; if (bus.sclk !== 1'b0)      begin errors++; $display("FAIL abort_sclk: got %b want 0", bus.sclk); end
        checks++; if (bus.rx_wr_en !== 1'b0)  begin errors++; $display("FAIL abort_rx_wr_en: got %b want 0", bus.rx_wr_en); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (n_rx - s_rx !== 0)      begin errors++; $display("FAIL abort_no_push: got %0d want 0", n_rx - s_rx); end
        s_rx = n_rx;
        push(8'h96);
        wait_done(300, "abort_next");
        checks++; if (rx_log[s_rx % 64] !== 8'h96 || n_rx - s_rx !== 1)
            begin errors++; $display("FAIL abort_next_byte: got %h (count %0d) want 96 (count 1)", rx_log[s_rx % 64], n_rx - s_rx); end
    endtask

    initial begin
        test_reset();
        test_mode0_loopback();
        test_mode3_div3();
        test_back_to_back();
        test_rx_full();
        test_reset_mid_frame();
        checks++; if (n_bad_rd !== 0) begin errors++; $display("FAIL rd_while_empty: got %0d want 0", n_bad_rd); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
